// File: rtl/bf_sequencer.sv
`timescale 1ns/1ps
// bf_sequencer: fetches BF program bytes from a synchronous ROM and issues single-cycle tape ops.
// Latency: 2 cycles per +,-,<,>; '.' ',' '[' ']' add a tape read or host handshake; scans take 2 cycles/byte.
// Backpressure: '.' holds out_valid/out_data until out_ready; ',' holds in_ready until in_valid.
//
// Ports:
//   clk, rst                 single rising-edge clock, asynchronous active-high reset
//   start                    begin a run at pc=0 (only from IDLE/HALT/ERR)
//   prog_addr / prog_data    ROM address (= pc) and the byte for last cycle's address
//   t_plus/t_minus/t_prev/t_next  tape op pulses (cell+1, cell-1, ptr-1, ptr+1)
//   t_outp / t_rdata         tape read pulse; cell value is valid the following cycle
//   t_write / t_wdata        tape write pulse and data (last accepted host input byte)
//   out_valid/out_ready/out_data  '.' result to the host
//   in_ready/in_valid/in_data     ',' input from the host
//   busy / halted / error    run status
module bf_sequencer #(
    parameter int PC_W    = 8,
    parameter int DEPTH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    output logic            t_plus,
    output logic            t_minus,
    output logic            t_prev,
    output logic            t_next,
    output logic            t_outp,
    input  logic [7:0]      t_rdata,
    output logic            t_write,
    output logic [7:0]      t_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            busy,
    output logic            halted,
    output logic            error
);

    // Program characters
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_PLUS  = 8'h2B;  // +
    localparam logic [7:0] CH_COMMA = 8'h2C;  // ,
    localparam logic [7:0] CH_MINUS = 8'h2D;  // -
    localparam logic [7:0] CH_DOT   = 8'h2E;  // .
    localparam logic [7:0] CH_LT    = 8'h3C;  // <
    localparam logic [7:0] CH_GT    = 8'h3E;  // >
    localparam logic [7:0] CH_LBR   = 8'h5B;  // [
    localparam logic [7:0] CH_RBR   = 8'h5D;  // ]

    localparam logic [PC_W-1:0]    PC_ZERO   = '0;
    localparam logic [PC_W-1:0]    PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]    PC_MAX    = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RDWAIT,
        S_CHK,
        S_OUT_WAIT,
        S_IN_WAIT,
        S_SCAN_F,
        S_SCAN_B,
        S_HALT,
        S_ERR
    } state_t;

    // Which instruction issued the pending tape read
    typedef enum logic [1:0] {
        OP_DOT,
        OP_LBR,
        OP_RBR
    } op_t;

    state_t               state;
    op_t                  op_q;
    logic [PC_W-1:0]      pc;
    logic [DEPTH_W-1:0]   depth;
    logic [7:0]           cell_q;
    logic [7:0]           wdata_q;
    logic                 scan_cmp;   // 0: address phase of a scan byte, 1: compare phase

    logic                 pc_last;
    logic                 pc_first;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      pc_dec;
    logic                 depth_full;
    logic                 depth_one;
    logic [DEPTH_W-1:0]   depth_inc;
    logic [DEPTH_W-1:0]   depth_dec;

    assign pc_last    = (pc == PC_MAX);
    assign pc_first   = (pc == PC_ZERO);
    assign pc_inc     = pc + PC_ONE;
    assign pc_dec     = pc - PC_ONE;
    assign depth_full = (depth == DEPTH_MAX);
    assign depth_one  = (depth == DEPTH_ONE);
    assign depth_inc  = depth + DEPTH_ONE;
    assign depth_dec  = depth - DEPTH_ONE;

    assign prog_addr = pc;
    assign busy      = (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);
    assign halted    = (state == S_HALT);
    assign error     = (state == S_ERR);

    // Tape pulses are decoded straight from the ROM byte in DECODE so the op lands in the
    // same cycle the instruction is seen; the ROM output is itself registered.
    always_comb begin
        t_plus  = 1'b0;
        t_minus = 1'b0;
        t_prev  = 1'b0;
        t_next  = 1'b0;
        t_outp  = 1'b0;
        if (state == S_DECODE) begin
            case (prog_data)
                CH_PLUS:                t_plus  = 1'b1;
                CH_MINUS:               t_minus = 1'b1;
                CH_LT:                  t_prev  = 1'b1;
                CH_GT:                  t_next  = 1'b1;
                CH_DOT, CH_LBR, CH_RBR: t_outp  = 1'b1;
                default:                ;
            endcase
        end
    end

    assign t_write = (state == S_IN_WAIT) && in_valid && in_ready;
    // During the write cycle the fresh host byte must already be on t_wdata; afterwards the
    // register holds it.
    assign t_wdata = t_write ? in_data : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_DOT;
            pc        <= PC_ZERO;
            depth     <= DEPTH_ZERO;
            cell_q    <= 8'h00;
            wdata_q   <= 8'h00;
            scan_cmp  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        pc       <= PC_ZERO;
                        depth    <= DEPTH_ZERO;
                        scan_cmp <= 1'b0;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    case (prog_data)
                        CH_NUL: state <= S_HALT;
                        CH_DOT: begin
                            op_q  <= OP_DOT;
                            state <= S_RDWAIT;
                        end
                        CH_LBR: begin
                            op_q  <= OP_LBR;
                            state <= S_RDWAIT;
                        end
                        CH_RBR: begin
                            op_q  <= OP_RBR;
                            state <= S_RDWAIT;
                        end
                        CH_COMMA: begin
                            in_ready <= 1'b1;
                            state    <= S_IN_WAIT;
                        end
                        // Tape ops and comment bytes simply advance
                        default: begin
                            if (pc_last) begin
                                state <= S_ERR;
                            end else begin
                                pc    <= pc_inc;
                                state <= S_FETCH;
                            end
                        end
                    endcase
                end

                S_RDWAIT: begin
                    cell_q <= t_rdata;
                    if (op_q == OP_DOT) begin
                        out_data  <= t_rdata;
                        out_valid <= 1'b1;
                        state     <= S_OUT_WAIT;
                    end else begin
                        state <= S_CHK;
                    end
                end

                S_CHK: begin
                    if (op_q == OP_LBR) begin
                        // '[' enters the scan one past itself, so both outcomes need pc+1
                        if (pc_last) begin
                            state <= S_ERR;
                        end else begin
                            pc <= pc_inc;
                            if (cell_q != 8'h00) begin
                                state <= S_FETCH;
                            end else begin
                                depth    <= DEPTH_ONE;
                                scan_cmp <= 1'b0;
                                state    <= S_SCAN_F;
                            end
                        end
                    end else begin
                        if (cell_q == 8'h00) begin
                            if (pc_last) begin
                                state <= S_ERR;
                            end else begin
                                pc    <= pc_inc;
                                state <= S_FETCH;
                            end
                        end else if (pc_first) begin
                            state <= S_ERR;
                        end else begin
                            depth    <= DEPTH_ONE;
                            pc       <= pc_dec;
                            scan_cmp <= 1'b0;
                            state    <= S_SCAN_B;
                        end
                    end
                end

                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pc_last) begin
                            state <= S_ERR;
                        end else begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    end
                end

                S_IN_WAIT: begin
                    if (in_valid) begin
                        wdata_q  <= in_data;
                        in_ready <= 1'b0;
                        if (pc_last) begin
                            state <= S_ERR;
                        end else begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    end
                end

                S_SCAN_F: begin
                    scan_cmp <= ~scan_cmp;
                    if (scan_cmp) begin
                        if (prog_data == CH_NUL) begin
                            state <= S_ERR;
                        end else if (prog_data == CH_LBR && depth_full) begin
                            state <= S_ERR;
                        end else if (pc_last) begin
                            // Either another byte or the byte after the closing ']' is needed
                            state <= S_ERR;
                        end else begin
                            pc <= pc_inc;
                            if (prog_data == CH_LBR) begin
                                depth <= depth_inc;
                            end else if (prog_data == CH_RBR) begin
                                depth <= depth_dec;
                                if (depth_one) begin
                                    state <= S_FETCH;
                                end
                            end
                        end
                    end
                end

                S_SCAN_B: begin
                    scan_cmp <= ~scan_cmp;
                    if (scan_cmp) begin
                        if (prog_data == CH_LBR && depth_one) begin
                            // The matching '[' sits before the originating ']', so pc+1 is safe
                            depth <= DEPTH_ZERO;
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end else if (prog_data == CH_RBR && depth_full) begin
                            state <= S_ERR;
                        end else if (pc_first) begin
                            state <= S_ERR;
                        end else begin
                            pc <= pc_dec;
                            if (prog_data == CH_RBR) begin
                                depth <= depth_inc;
                            end else if (prog_data == CH_LBR) begin
                                depth <= depth_dec;
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_sequencer.sv
`timescale 1ns/1ps
// tb_bf_sequencer: runs BF programs through bf_sequencer with ROM, tape and host models and
// compares outputs, pulse counts and final status against a behavioural interpreter.
module tb_bf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       t_plus, t_minus, t_prev, t_next, t_outp, t_write;
    logic [7:0] t_rdata, t_wdata;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       in_ready, in_valid;
    logic [7:0] in_data;
    logic       busy, halted, error;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bf_sequencer #(.PC_W(8), .DEPTH_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .t_plus(t_plus), .t_minus(t_minus), .t_prev(t_prev), .t_next(t_next),
        .t_outp(t_outp), .t_rdata(t_rdata), .t_write(t_write), .t_wdata(t_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .halted(halted), .error(error)
    );

    // ---------------- ROM and tape models ----------------
    logic [7:0] rom  [0:255];
    logic [7:0] tape [0:255];
    logic [7:0] tptr;
    logic       tape_clr = 1'b1;

    always @(posedge clk) prog_data <= rom[prog_addr];

    always @(posedge clk) begin
        if (tape_clr) begin
            for (int i = 0; i < 256; i++) tape[i] <= 8'h00;
            tptr <= 8'h00;
        end else begin
            if (t_plus)  tape[tptr] <= tape[tptr] + 8'd1;
            if (t_minus) tape[tptr] <= tape[tptr] - 8'd1;
            if (t_write) tape[tptr] <= t_wdata;
            if (t_prev)  tptr <= tptr - 8'd1;
            if (t_next)  tptr <= tptr + 8'd1;
        end
    end
    assign t_rdata = tape[tptr];

    // ---------------- host model ----------------
    logic [7:0] inq[$];
    int         in_idx;
    int         ready_mode = 2;   // 0 random, 1 held low, 2 held high

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
        if (in_ready && in_idx < inq.size() && $urandom_range(0, 2) != 0) begin
            in_valid = 1'b1;
            in_data  = inq[in_idx];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    end

    // ---------------- activity monitor ----------------
    logic       mon_clr = 1'b1;
    int         plus_cnt, outp_cnt, bwd_cnt, multi_err, stab_err;
    logic [7:0] got_outs[$];
    logic [7:0] last_addr, held;
    logic       dec_run, holding;

    always @(posedge clk) begin
        if (mon_clr) begin
            plus_cnt = 0; outp_cnt = 0; bwd_cnt = 0; multi_err = 0; stab_err = 0;
            got_outs.delete();
            in_idx = 0; holding = 1'b0; dec_run = 1'b0; last_addr = prog_addr;
        end else begin
            plus_cnt += int'(t_plus);
            outp_cnt += int'(t_outp);
            if ($countones({t_plus, t_minus, t_prev, t_next, t_outp, t_write}) > 1) multi_err++;
            // Each run of falling addresses is one backward jump
            if (prog_addr < last_addr) begin
                if (!dec_run) bwd_cnt++;
                dec_run = 1'b1;
            end else if (prog_addr > last_addr) begin
                dec_run = 1'b0;
            end
            last_addr = prog_addr;
            if (in_valid && in_ready) in_idx++;
            if (holding && (!out_valid || out_data !== held)) stab_err++;
            if (out_valid && out_ready) begin
                got_outs.push_back(out_data);
                holding = 1'b0;
            end else if (out_valid) begin
                holding = 1'b1;
                held    = out_data;
            end
        end
    end

    // ---------------- reference interpreter ----------------
    logic [7:0] m_outs[$];
    int         m_plus, m_outp, m_bwd, m_status;  // status 1 halt, 2 error, 3 too long

    function automatic void ref_run();
        logic [7:0] mt [256];
        logic [7:0] p, c, b;
        int         pc, d, steps, ii;
        for (int i = 0; i < 256; i++) mt[i] = 8'h00;
        p = 0; pc = 0; ii = 0; steps = 0;
        m_outs.delete(); m_plus = 0; m_outp = 0; m_bwd = 0; m_status = 0;
        while (m_status == 0) begin
            c = rom[pc];
            if (c == 8'h00) begin
                m_status = 1;
                break;
            end
            case (c)
                8'h2B: begin mt[p] = mt[p] + 8'd1; m_plus++; end
                8'h2D: mt[p] = mt[p] - 8'd1;
                8'h3C: p = p - 8'd1;
                8'h3E: p = p + 8'd1;
                8'h2E: begin m_outp++; m_outs.push_back(mt[p]); end
                8'h2C: begin
                    if (ii < inq.size()) mt[p] = inq[ii];
                    else m_status = 3;
                    ii++;
                end
                8'h5B: begin
                    m_outp++;
                    if (mt[p] == 8'h00) begin
                        d = 1;
                        while (d != 0) begin
                            if (pc == 255) begin m_status = 2; break; end
                            pc++;
                            b = rom[pc];
                            if (b == 8'h00) begin m_status = 2; break; end
                            if (b == 8'h5B) d++;
                            else if (b == 8'h5D) d--;
                        end
                    end
                end
                8'h5D: begin
                    m_outp++;
                    if (mt[p] != 8'h00) begin
                        m_bwd++;
                        d = 1;
                        while (d != 0) begin
                            if (pc == 0) begin m_status = 2; break; end
                            pc--;
                            b = rom[pc];
                            if (b == 8'h5D) d++;
                            else if (b == 8'h5B) d--;
                        end
                    end
                end
                default: ;
            endcase
            if (m_status != 0) break;
            if (pc == 255) m_status = 2;
            else pc++;
            steps++;
            if (steps > 150 && m_status == 0) m_status = 3;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic load_str(input string s);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    task automatic start_run();
        tape_clr = 1'b1; mon_clr = 1'b1; start = 1'b1;
        @(negedge clk);
        tape_clr = 1'b0; start = 1'b0;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    // st: 1 halted, 2 error, 0 cycle budget exhausted
    task automatic run_prog(output int st);
        start_run();
        st = 0;
        for (int i = 0; i < 20000; i++) begin
            if (halted || error) begin
                st = halted ? 1 : 2;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rst = 1'b1; start = 1'b0;
        #2;
        checks++;
        if ({busy, halted, error, out_valid, in_ready, t_plus, t_minus, t_prev, t_next, t_outp, t_write} !== 11'd0) begin
            errs++; $display("FAIL reset_flags: got %b want 0", {busy, halted, error, out_valid, in_ready});
        end
        checks++;
        if (prog_addr !== 8'h00 || out_data !== 8'h00 || t_wdata !== 8'h00) begin
            errs++; $display("FAIL reset_data: got addr=%h out=%h wd=%h want 0", prog_addr, out_data, t_wdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || prog_addr !== 8'h00) begin
            errs++; $display("FAIL idle_no_start: got busy=%b addr=%h want 0/00", busy, prog_addr);
        end
    endtask

    task automatic test_plus3();
        int st;
        load_str("+++."); inq.delete(); ready_mode = 0; ref_run();
        run_prog(st);
        checks++;
        if (st != 1 || error !== 1'b0) begin errs++; $display("FAIL plus3_status: got %0d want 1", st); end
        checks++;
        if (plus_cnt != 3) begin errs++; $display("FAIL plus3_pulses: got %0d want 3", plus_cnt); end
        checks++;
        if (got_outs.size() != 1 || got_outs[0] !== 8'h03) begin
            errs++; $display("FAIL plus3_out: got n=%0d want 1 byte 03", got_outs.size());
        end
    endtask

    task automatic test_nested_skip();
        int st;
        load_str("[+[+]+]-."); inq.delete(); ready_mode = 0; ref_run();
        run_prog(st);
        checks++;
        if (st != 1) begin errs++; $display("FAIL skip_status: got %0d want 1", st); end
        checks++;
        if (plus_cnt != 0) begin errs++; $display("FAIL skip_pulses: got %0d want 0", plus_cnt); end
        checks++;
        if (got_outs.size() != 1 || got_outs[0] !== 8'hFF) begin
            errs++; $display("FAIL skip_out: got n=%0d want 1 byte ff", got_outs.size());
        end
    endtask

    task automatic test_loop();
        int st;
        load_str("++[>+<-]>."); inq.delete(); ready_mode = 0; ref_run();
        run_prog(st);
        checks++;
        if (st != 1) begin errs++; $display("FAIL loop_status: got %0d want 1", st); end
        checks++;
        if (got_outs.size() != 1 || got_outs[0] !== 8'h02) begin
            errs++; $display("FAIL loop_out: got n=%0d want 1 byte 02", got_outs.size());
        end
        // Two passes of the body; the ']' check jumps back after the first pass only
        checks++;
        if (bwd_cnt != m_bwd || outp_cnt != m_outp) begin
            errs++; $display("FAIL loop_jumps: got bwd=%0d rd=%0d want bwd=%0d rd=%0d", bwd_cnt, outp_cnt, m_bwd, m_outp);
        end
    endtask

    task automatic test_io_backpressure();
        bit seen = 1'b0;
        int st;
        load_str(",."); inq.delete(); inq.push_back(8'h41); ready_mode = 1;
        start_run();
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errs++; $display("FAIL io_valid_timeout: got none want out_valid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41) begin
                errs++; $display("FAIL io_hold%0d: got v=%b d=%h want 1/41", i, out_valid, out_data);
            end
        end
        checks++;
        if (t_wdata !== 8'h41 || tape[0] !== 8'h41) begin
            errs++; $display("FAIL io_write: got wd=%h cell=%h want 41", t_wdata, tape[0]);
        end
        ready_mode = 2;
        st = 0;
        for (int i = 0; i < 200; i++) begin
            if (halted || error) begin st = halted ? 1 : 2; break; end
            @(negedge clk);
        end
        checks++;
        if (st != 1 || got_outs.size() != 1 || got_outs[0] !== 8'h41 || stab_err != 0) begin
            errs++; $display("FAIL io_accept: got st=%0d n=%0d stab=%0d want 1/1/0", st, got_outs.size(), stab_err);
        end
    endtask

    task automatic test_errors();
        int st;
        load_str("+]"); inq.delete(); ready_mode = 0;
        run_prog(st);
        checks++;
        if (st != 2 || busy !== 1'b0) begin errs++; $display("FAIL err_bwd: got %0d want 2", st); end
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin errs++; $display("FAIL err_hold: got %b want 1", error); end
        load_str("[");
        run_prog(st);
        checks++;
        if (st != 2) begin errs++; $display("FAIL err_fwd: got %0d want 2", st); end
    endtask

    task automatic test_reset_mid_scan();
        int         st;
        logic [7:0] pc0;
        load_str("[");
        for (int i = 1; i <= 60; i++) rom[i] = 8'h78;
        rom[61] = 8'h5D; rom[62] = 8'h2E;
        inq.delete(); ready_mode = 0;
        start_run();
        repeat (30) @(negedge clk);
        pc0 = prog_addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || prog_addr < pc0 || prog_addr == 8'h00) begin
            errs++; $display("FAIL start_ignored: got busy=%b addr=%h want 1 and >=%h", busy, prog_addr, pc0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, halted, error, out_valid, in_ready, t_plus, t_minus, t_prev, t_next, t_outp, t_write} !== 11'd0
            || prog_addr !== 8'h00 || out_data !== 8'h00 || t_wdata !== 8'h00) begin
            errs++; $display("FAIL mid_reset: got busy=%b addr=%h out=%h wd=%h want all 0", busy, prog_addr, out_data, t_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        ref_run();
        run_prog(st);
        checks++;
        if (st != 1 || plus_cnt != 0 || got_outs.size() != 1 || got_outs[0] !== 8'h00) begin
            errs++; $display("FAIL rerun: got st=%0d plus=%0d n=%0d want 1/0/1", st, plus_cnt, got_outs.size());
        end
    endtask

    task automatic test_random();
        int  st, ran, open, len;
        bit  ok;
        ran = 0;
        for (int t = 0; t < 80 && ran < 10; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'h00;
            len = $urandom_range(4, 14); open = 0;
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 9))
                    0, 1: rom[i] = 8'h2B;
                    2:    rom[i] = 8'h2D;
                    3:    rom[i] = 8'h3E;
                    4:    rom[i] = 8'h3C;
                    5:    rom[i] = 8'h2E;
                    6:    rom[i] = 8'h2C;
                    7:    if (open < 2) begin rom[i] = 8'h5B; open++; end else rom[i] = 8'h2B;
                    8:    if (open > 0) begin rom[i] = 8'h5D; open--; end else rom[i] = 8'h2E;
                    default: rom[i] = 8'h78;
                endcase
            end
            for (int i = 0; i < open; i++) rom[len + i] = 8'h5D;
            inq.delete();
            for (int i = 0; i < 16; i++) inq.push_back(8'($urandom));
            ref_run();
            if (m_status == 3) continue;
            ran++;
            ready_mode = 0;
            run_prog(st);
            checks++;
            if (st != m_status) begin errs++; $display("FAIL rnd%0d_status: got %0d want %0d", ran, st, m_status); end
            ok = (got_outs.size() == m_outs.size());
            if (ok) foreach (m_outs[i]) if (got_outs[i] !== m_outs[i]) ok = 1'b0;
            checks++;
            if (!ok) begin errs++; $display("FAIL rnd%0d_outs: got n=%0d want n=%0d (or byte differs)", ran, got_outs.size(), m_outs.size()); end
            checks++;
            if (plus_cnt != m_plus || outp_cnt != m_outp) begin
                errs++; $display("FAIL rnd%0d_pulses: got plus=%0d rd=%0d want %0d/%0d", ran, plus_cnt, outp_cnt, m_plus, m_outp);
            end
            checks++;
            if (bwd_cnt != m_bwd) begin errs++; $display("FAIL rnd%0d_bwd: got %0d want %0d", ran, bwd_cnt, m_bwd); end
            checks++;
            if (multi_err != 0 || stab_err != 0) begin
                errs++; $display("FAIL rnd%0d_proto: got multi=%0d stab=%0d want 0/0", ran, multi_err, stab_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plus3();
        test_nested_skip();
        test_loop();
        test_io_backpressure();
        test_errors();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
